// File: rtl/spi_controller_if.sv
// spi_controller_if: config and strobe bundle between the SPI register block, spi_controller and spi_datapath.
// master = controller side, slave = register block / datapath side.
interface spi_controller_if #(
    parameter int DIV_W = 8
);
    logic             spi_en;
    logic             cpol;
    logic             cpha;
    logic [DIV_W-1:0] clk_div;
    logic             tx_fifo_empty;
    logic             sclk;
    logic             cs_n;
    logic             tx_fifo_read;
    logic             tx_shift_load;
    logic             mosi_first_en;
    logic             mosi_transmit_en;
    logic             miso_en;
    logic             mosi_mux_sel;
    logic             rx_fifo_write;
    logic             busy;
    logic             done;

    modport master (
        input  spi_en, cpol, cpha, clk_div, tx_fifo_empty,
        output sclk, cs_n, tx_fifo_read, tx_shift_load, mosi_first_en, mosi_transmit_en,
               miso_en, mosi_mux_sel, rx_fifo_write, busy, done
    );

    modport slave (
        output spi_en, cpol, cpha, clk_div, tx_fifo_empty,
        input  sclk, cs_n, tx_fifo_read, tx_shift_load, mosi_first_en, mosi_transmit_en,
               miso_en, mosi_mux_sel, rx_fifo_write, busy, done
    );
endinterface

// File: rtl/spi_controller.sv
// spi_controller: SPI master sequencer generating SCLK, CS and per-bit shift/sample strobes, CPOL/CPHA modes 0-3.
// Define SPI_CS_BURST_EN to chain queued bytes straight from TRAIL into LOAD with CS held low.
module spi_controller #(
    parameter int DIV_W = 8
) (
    input logic clk,
    input logic rst,
    spi_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SETUP, XFER, TRAIL} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n, div, div_n;
    logic [3:0]       edg, edg_n;
    logic             cpol, cpol_n, cpha, cpha_n;
    logic             start, last, xfer_edge, sclk_n;

    // edg holds (SCLK edge number - 1) for the current XFER half-period
    always_comb begin
        state_n = state;
        cnt_n   = cnt + DIV_W'(1);
        edg_n   = edg;
        start   = bus.spi_en && !bus.tx_fifo_empty;
        last    = cnt == div;
        case (state)
            IDLE:  state_n = start ? LOAD : IDLE;
            LOAD:  state_n = SETUP;
            SETUP: state_n = last ? XFER : SETUP;
            XFER: if (last) begin
                edg_n   = edg + 4'd1;
                state_n = edg == 4'd15 ? TRAIL : XFER;
            end
            TRAIL: if (last) begin
`ifdef SPI_CS_BURST_EN
                state_n = start ? LOAD : IDLE;
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        if (last || state_n != state) cnt_n = '0;
        if (state_n != XFER) edg_n = '0;
        cpol_n    = state_n == LOAD ? bus.cpol : cpol;
        cpha_n    = state_n == LOAD ? bus.cpha : cpha;
        div_n     = state_n == LOAD ? bus.clk_div : div;
        xfer_edge = state_n == XFER && cnt_n == '0;
        sclk_n    = state_n == IDLE ? bus.cpol : state_n == XFER ? bus.sclk ^ xfer_edge : cpol_n;
    end

    // Outputs are registered from the next-state values so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            cnt                  <= '0;
            edg                  <= '0;
            div                  <= '0;
            cpol                 <= 1'b0;
            cpha                 <= 1'b0;
            bus.sclk             <= 1'b0;
            bus.cs_n             <= 1'b1;
            bus.tx_fifo_read     <= 1'b0;
            bus.tx_shift_load    <= 1'b0;
            bus.mosi_first_en    <= 1'b0;
            bus.mosi_transmit_en <= 1'b0;
            bus.miso_en          <= 1'b0;
            bus.mosi_mux_sel     <= 1'b0;
            bus.rx_fifo_write    <= 1'b0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
        end else begin
            state                <= state_n;
            cnt                  <= cnt_n;
            edg                  <= edg_n;
            div                  <= div_n;
            cpol                 <= cpol_n;
            cpha                 <= cpha_n;
            bus.sclk             <= sclk_n;
            bus.cs_n             <= state_n == IDLE;
            bus.tx_fifo_read     <= state_n == LOAD;
            bus.tx_shift_load    <= state_n == LOAD;
            bus.mosi_first_en    <= state_n == SETUP && cnt_n == '0 && !cpha_n;
            bus.mosi_transmit_en <= xfer_edge && (cpha_n ? !edg_n[0] : edg_n[0] && edg_n != 4'd15);
            bus.miso_en          <= xfer_edge && (cpha_n ? edg_n[0] : !edg_n[0]);
            bus.mosi_mux_sel     <= state_n != IDLE;
            bus.rx_fifo_write    <= state_n == TRAIL && cnt_n == '0;
            bus.busy             <= state_n != IDLE;
            bus.done             <= state_n == TRAIL && cnt_n == div_n;
        end
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed bench for spi_controller with a small shift-register model of the datapath and slave.
module tb_spi_controller;
`ifdef SPI_CS_BURST_EN
    localparam int GAP = 0, LAST2 = 38;
`else
    localparam int GAP = 1, LAST2 = 39;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0, errors = 0;

    spi_controller_if #(.DIV_W(8)) bus ();
    spi_controller #(.DIV_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // datapath + slave model: TX shifter, MOSI register, RX shifter fed by an echo byte
    logic [7:0] tx_byte, echo, tx_sh, rx_sh, rx_fifo, mosi_seen;
    logic       mosi_q;
    logic [2:0] nbit;
    int         rxw_total = 0;

    always @(posedge clk) begin
        if (bus.tx_shift_load) begin
            tx_sh <= tx_byte;
            nbit  <= 3'd0;
        end else if (bus.mosi_first_en || bus.mosi_transmit_en) begin
            mosi_q <= tx_sh[7];
            tx_sh  <= {tx_sh[6:0], 1'b0};
        end
        if (bus.miso_en) begin
            rx_sh     <= {rx_sh[6:0], echo[3'd7 - nbit]};
            mosi_seen <= {mosi_seen[6:0], mosi_q & bus.mosi_mux_sel};
            nbit      <= nbit + 3'd1;
        end
        if (bus.rx_fifo_write) begin
            rx_fifo   <= rx_sh;
            rxw_total <= rxw_total + 1;
        end
    end

    int cs_low, cs_first, cs_last, gap, rises, falls, rise_prev, rise_last, reads, read_at;
    int rxw_n, rxw_at, done_n, done_at, miso_n, tx_n, first_n, busy_n, miso_rise, tx_fall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watches n cycles after a request placed in cycle 0; empties the TX FIFO after nbytes pops
    task automatic observe(input int n, input int nbytes, input int chg_at, input logic [7:0] chg_div);
        logic p;
        int   hi_run;
        bit   seen;
        p = bus.sclk; hi_run = 0; seen = 0;
        cs_low = 0; cs_first = 0; cs_last = 0; gap = 0; rises = 0; falls = 0; rise_prev = 0; rise_last = 0;
        reads = 0; read_at = 0; rxw_n = 0; rxw_at = 0; done_n = 0; done_at = 0; miso_n = 0; tx_n = 0;
        first_n = 0; busy_n = 0; miso_rise = 0; tx_fall = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (!bus.cs_n) begin
                cs_low++;
                if (cs_first == 0) cs_first = c;
                cs_last = c;
                if (seen && hi_run > 0) gap = hi_run;
                hi_run = 0;
                seen = 1;
            end else if (seen) hi_run++;
            if (bus.sclk && !p) begin
                rises++;
                rise_prev = rise_last;
                rise_last = c;
                if (bus.miso_en) miso_rise++;
            end
            if (!bus.sclk && p) begin
                falls++;
                if (bus.mosi_transmit_en) tx_fall++;
            end
            p = bus.sclk;
            if (bus.tx_fifo_read) begin
                reads++;
                if (read_at == 0) read_at = c;
            end
            if (bus.rx_fifo_write) begin rxw_n++; rxw_at = c; end
            if (bus.done) begin done_n++; done_at = c; end
            if (bus.miso_en) miso_n++;
            if (bus.mosi_transmit_en) tx_n++;
            if (bus.mosi_first_en) first_n++;
            if (bus.busy) busy_n++;
            if (reads >= nbytes) bus.tx_fifo_empty = 1'b1;
            if (c == chg_at) bus.clk_div = chg_div;
        end
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.spi_en = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = 8'd0; bus.tx_fifo_empty = 1'b1;
        tx_byte = 8'h00; echo = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(bus.sclk), 0);
        chk("rst_cs_n", 32'(bus.cs_n), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_strobes", 32'({bus.tx_fifo_read, bus.tx_shift_load, bus.mosi_first_en, bus.mosi_transmit_en,
                                bus.miso_en, bus.mosi_mux_sel, bus.rx_fifo_write, bus.done}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // mode 0, div 0, TX A5, slave echoes 3C
        tx_byte = 8'hA5; echo = 8'h3C; bus.spi_en = 1'b1; bus.tx_fifo_empty = 1'b0;
        observe(25, 1, 0, 8'd0);
        chk("m0_read_at", read_at, 1);
        chk("m0_cs_first", cs_first, 1);
        chk("m0_cs_last", cs_last, 19);
        chk("m0_cs_low", cs_low, 19);
        chk("m0_rises", rises, 8);
        chk("m0_falls", falls, 8);
        chk("m0_period", rise_last - rise_prev, 2);
        chk("m0_first_en", first_n, 1);
        chk("m0_tx_en", tx_n, 7);
        chk("m0_miso_rise", miso_rise, 8);
        chk("m0_rxw_at", rxw_at, 19);
        chk("m0_done_at", done_at, 19);
        chk("m0_done_n", done_n, 1);
        chk("m0_mosi", 32'(mosi_seen), 32'hA5);
        chk("m0_rx", 32'(rx_fifo), 32'h3C);

        // mode 3, div 3, TX 81, slave echoes 5A
        bus.cpol = 1'b1; bus.cpha = 1'b1; bus.clk_div = 8'd3;
        repeat (2) @(negedge clk);
        chk("m3_idle_sclk", 32'(bus.sclk), 1);
        tx_byte = 8'h81; echo = 8'h5A; bus.tx_fifo_empty = 1'b0;
        observe(85, 1, 0, 8'd3);
        chk("m3_cs_low", cs_low, 73);
        chk("m3_period", rise_last - rise_prev, 8);
        chk("m3_rises", rises, 8);
        chk("m3_first_en", first_n, 0);
        chk("m3_tx_fall", tx_fall, 8);
        chk("m3_miso_rise", miso_rise, 8);
        chk("m3_rxw_at", rxw_at, 70);
        chk("m3_done_at", done_at, 73);
        chk("m3_end_sclk", 32'(bus.sclk), 1);
        chk("m3_mosi", 32'(mosi_seen), 32'h81);
        chk("m3_rx", 32'(rx_fifo), 32'h5A);

        // two bytes queued, mode 0, div 0
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = 8'd0;
        repeat (2) @(negedge clk);
        tx_byte = 8'hC3; echo = 8'h96; bus.tx_fifo_empty = 1'b0;
        observe(45, 2, 0, 8'd0);
        chk("b2_cs_low", cs_low, 38);
        chk("b2_gap", gap, GAP);
        chk("b2_cs_last", cs_last, LAST2);
        chk("b2_done_n", done_n, 2);
        chk("b2_rxw_n", rxw_n, 2);
        chk("b2_rx", 32'(rx_fifo), 32'h96);

        // reset at XFER edge 9 (cycle 11 at div 0)
        base = rxw_total;
        bus.tx_fifo_empty = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) bus.tx_fifo_empty = 1'b1;
        end
        chk("r_edge9", 32'({bus.sclk, bus.miso_en}), 32'h3);
        rst = 1'b1;
        @(negedge clk);
        chk("r_cs_n", 32'(bus.cs_n), 1);
        chk("r_sclk", 32'(bus.sclk), 0);
        chk("r_busy", 32'(bus.busy), 0);
        rst = 1'b0; bus.spi_en = 1'b0;
        repeat (30) @(negedge clk);
        chk("r_no_rxw", rxw_total - base, 0);
        chk("r_idle_busy", 32'(bus.busy), 0);
        bus.spi_en = 1'b1;

        // clk_div 5 -> 0 mid-frame, then a frame at the new divider
        bus.clk_div = 8'd5;
        repeat (2) @(negedge clk);
        bus.tx_fifo_empty = 1'b0;
        observe(115, 1, 30, 8'd0);
        chk("d5_cs_low", cs_low, 109);
        chk("d5_period", rise_last - rise_prev, 12);
        chk("d5_done_at", done_at, 109);
        bus.tx_fifo_empty = 1'b0;
        observe(25, 1, 0, 8'd0);
        chk("d0_cs_low", cs_low, 19);
        chk("d0_period", rise_last - rise_prev, 2);

        // empty TX FIFO with enable held
        bus.tx_fifo_empty = 1'b1;
        observe(100, 0, 0, 8'd0);
        chk("e_cs_low", cs_low, 0);
        chk("e_busy", busy_n, 0);
        chk("e_strobes", reads + miso_n + tx_n + first_n + rxw_n + done_n + rises, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
